// File: rtl/instr_aligner_pkg.sv
// Shared configuration for the instruction aligner: halfword width,
// RVC quadrant encoding and the compressed-instruction test.
`ifndef C_EXTENSION
`define C_EXTENSION 1
`endif

package instr_aligner_pkg;
    localparam int         HW_W          = 16;
    localparam logic [1:0] RVC_QUAD_FULL = 2'b11;
    localparam bit         C_EN_DEFAULT  = bit'(`C_EXTENSION);

    // A halfword starts a compressed instruction unless its low bits mark a full-width one.
    function automatic logic is_rvc(input logic [HW_W-1:0] hw, input bit c_en);
        return c_en && (hw[1:0] != RVC_QUAD_FULL);
    endfunction
endpackage

// File: rtl/instr_aligner_if.sv
// Fetch-side and decode-side handshake bundle of the instruction aligner.
// master = fetch/decode environment, slave = the aligner itself.
interface instr_aligner_if #(
    parameter int DEPTH_HW = 8
);
    localparam int LEVEL_W = $clog2(DEPTH_HW) + 1;

    logic               i_flush;
    logic [31:0]        i_flush_pc;
    logic               i_fetch_valid;
    logic               o_fetch_ready;
    logic [31:0]        i_fetch_data;
    logic               o_instr_valid;
    logic               i_instr_ready;
    logic [31:0]        o_instr;
    logic               o_instr_c;
    logic [31:0]        o_instr_pc;
    logic [LEVEL_W-1:0] o_level;

    modport master (
        output i_flush, i_flush_pc, i_fetch_valid, i_fetch_data, i_instr_ready,
        input  o_fetch_ready, o_instr_valid, o_instr, o_instr_c, o_instr_pc, o_level
    );

    modport slave (
        input  i_flush, i_flush_pc, i_fetch_valid, i_fetch_data, i_instr_ready,
        output o_fetch_ready, o_instr_valid, o_instr, o_instr_c, o_instr_pc, o_level
    );
endinterface

// File: rtl/instr_aligner_hw_queue.sv
// Halfword circular buffer: one write port taking a whole fetch word (or only
// its upper halfword), two read ports exposing the head and the halfword after it.
module instr_aligner_hw_queue
    import instr_aligner_pkg::*;
#(
    parameter int DEPTH_HW = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clear,
    input  logic            push,
    input  logic            push_hi_only,
    input  logic [31:0]     data,
    input  logic            pop,
    input  logic            pop_two,
    output logic [HW_W-1:0] h0,
    output logic [HW_W-1:0] h1
);
    localparam int PTR_W = $clog2(DEPTH_HW);

    logic [HW_W-1:0]  mem [DEPTH_HW];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;

    // Pointers wrap naturally because DEPTH_HW is a power of two.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (push_hi_only ? PTR_W'(1) : PTR_W'(2));
            if (pop)  rd_ptr <= rd_ptr + (pop_two ? PTR_W'(2) : PTR_W'(1));
        end
    end

    // Storage is left unreset; the top never presents a slot that was not written.
    always_ff @(posedge clk) begin
        if (push && !rst && !clear) begin
            if (push_hi_only) begin
                mem[wr_ptr] <= data[31:16];
            end else begin
                mem[wr_ptr]              <= data[15:0];
                mem[wr_ptr + PTR_W'(1)]  <= data[31:16];
            end
        end
    end

    assign h0 = mem[rd_ptr];
    assign h1 = mem[rd_ptr + PTR_W'(1)];
endmodule

// File: rtl/instr_aligner.sv
// Halfword-granular prefetch queue between fetch and decode. Tracks fill level,
// the PC of the head instruction and the pending branch-target halfword skip.
module instr_aligner
    import instr_aligner_pkg::*;
#(
    parameter int          DEPTH_HW = 8,
    parameter bit          C_EN     = C_EN_DEFAULT,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input logic            i_clk,
    input logic            i_rst,
    instr_aligner_if.slave bus
);
    localparam int          LEVEL_W = $clog2(DEPTH_HW) + 1;
    localparam logic [31:0] PC_MASK = C_EN ? 32'hFFFF_FFFE : 32'hFFFF_FFFC;

    logic [LEVEL_W-1:0] level;
    logic [31:0]        pc;
    logic               skip;
    logic [HW_W-1:0]    h0;
    logic [HW_W-1:0]    h1;
    logic               head_c;
    logic               fetch_ready;
    logic               valid;
    logic               push;
    logic               pop;
    logic [LEVEL_W-1:0] push_cnt;
    logic [LEVEL_W-1:0] pop_cnt;

    instr_aligner_hw_queue #(.DEPTH_HW(DEPTH_HW)) u_queue (
        .clk          (i_clk),
        .rst          (i_rst),
        .clear        (bus.i_flush),
        .push         (push),
        .push_hi_only (skip),
        .data         (bus.i_fetch_data),
        .pop          (pop),
        .pop_two      (!head_c),
        .h0           (h0),
        .h1           (h1)
    );

    // Head decode and handshake qualification; fetch_ready depends only on registered level.
    always_comb begin
        head_c      = is_rvc(h0, C_EN);
        fetch_ready = (level <= LEVEL_W'(DEPTH_HW - 2));
        push        = bus.i_fetch_valid && fetch_ready && !bus.i_flush;
        valid       = !bus.i_flush &&
                      (head_c ? (level >= LEVEL_W'(1)) : (level >= LEVEL_W'(2)));
        pop         = valid && bus.i_instr_ready;
        push_cnt    = push ? (skip ? LEVEL_W'(1) : LEVEL_W'(2)) : '0;
        pop_cnt     = pop ? (head_c ? LEVEL_W'(1) : LEVEL_W'(2)) : '0;
    end

    // Level, head PC and skip flag; reset beats flush, flush beats push/pop.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            level <= '0;
            pc    <= RESET_PC;
            skip  <= RESET_PC[1] & C_EN;
        end else if (bus.i_flush) begin
            level <= '0;
            pc    <= bus.i_flush_pc & PC_MASK;
            skip  <= bus.i_flush_pc[1] & C_EN;
        end else begin
            level <= level + push_cnt - pop_cnt;
            if (pop)  pc   <= pc + (head_c ? 32'd2 : 32'd4);
            if (push) skip <= 1'b0;
        end
    end

    assign bus.o_fetch_ready = fetch_ready;
    assign bus.o_instr_valid = valid;
    assign bus.o_instr       = !valid ? 32'h0 : (head_c ? {16'h0, h0} : {h1, h0});
    assign bus.o_instr_c     = valid && head_c;
    assign bus.o_instr_pc    = pc;
    assign bus.o_level       = level;
endmodule

// File: tb/tb_instr_aligner.sv
// Bench for instr_aligner: directed vector table, a pointer-wrap stall sequence,
// and a randomized run against a halfword-queue reference model.
module tb_instr_aligner;
    localparam int DEPTH_HW = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    instr_aligner_if #(.DEPTH_HW(DEPTH_HW)) bus ();

    instr_aligner #(.DEPTH_HW(DEPTH_HW), .C_EN(1'b1), .RESET_PC(32'h0)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        rst;
        logic        flush;
        logic [31:0] fpc;
        logic        fv;
        logic [31:0] fdata;
        logic        rdy;
        logic        chk;
        logic        ev;
        logic [31:0] ei;
        logic        ec;
        logic [31:0] epc;
        int          elv;
        logic        efr;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic f, input logic [31:0] fpc,
                                input logic fv, input logic [31:0] fd, input logic rdy,
                                input logic chk, input logic ev, input logic [31:0] ei,
                                input logic ec, input logic [31:0] epc, input int elv,
                                input logic efr);
        vec_t v;
        v.rst = r; v.flush = f; v.fpc = fpc; v.fv = fv; v.fdata = fd; v.rdy = rdy;
        v.chk = chk; v.ev = ev; v.ei = ei; v.ec = ec; v.epc = epc; v.elv = elv; v.efr = efr;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic ev, input logic [31:0] ei,
                              input logic ec, input logic [31:0] epc, input int elv,
                              input logic efr);
        check({tag, ".valid"}, 32'(bus.o_instr_valid), 32'(ev));
        check({tag, ".instr"}, bus.o_instr, ei);
        check({tag, ".c"},     32'(bus.o_instr_c), 32'(ec));
        check({tag, ".pc"},    bus.o_instr_pc, epc);
        check({tag, ".level"}, 32'(bus.o_level), 32'(elv));
        check({tag, ".fready"}, 32'(bus.o_fetch_ready), 32'(efr));
    endtask

    task automatic apply(input logic r, input logic f, input logic [31:0] fpc,
                         input logic fv, input logic [31:0] fd, input logic rdy);
        rst               = r;
        bus.i_flush       = f;
        bus.i_flush_pc    = fpc;
        bus.i_fetch_valid = fv;
        bus.i_fetch_data  = fd;
        bus.i_instr_ready = rdy;
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] rand_hw();
        logic [15:0] x;
        x = 16'($urandom);
        if ($urandom_range(0, 1) == 0) x[1:0] = 2'($urandom_range(0, 2));
        else                           x[1:0] = 2'b11;
        return x;
    endfunction

    // reference model state
    logic [15:0] mq[$];
    logic [31:0] mpc;
    logic        mskip;

    logic [31:0] w[5];
    logic        r_rst, r_flush, r_fv, r_rdy;
    logic [31:0] r_fpc, r_fdata;
    logic        e_c, e_v, e_fr, e_cc;
    logic [31:0] e_i;
    int          n;

    initial begin
        apply(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);

        // rst flush fpc fv fdata rdy | chk valid instr c pc level fready
        vecs.push_back(mk(1,0,32'h0,  0,32'h0,       0, 0,0,32'h0,       0,32'h0,  0,1));
        vecs.push_back(mk(0,0,32'h0,  1,32'h00130093,0, 1,0,32'h0,       0,32'h0,  0,1));
        vecs.push_back(mk(0,0,32'h0,  1,32'h00208113,0, 1,1,32'h00130093,0,32'h0,  2,1));
        vecs.push_back(mk(0,0,32'h0,  0,32'h0,       1, 1,1,32'h00130093,0,32'h0,  4,1));
        vecs.push_back(mk(0,0,32'h0,  0,32'h0,       1, 1,1,32'h00208113,0,32'h4,  2,1));
        vecs.push_back(mk(0,0,32'h0,  0,32'h0,       0, 1,0,32'h0,       0,32'h8,  0,1));
        vecs.push_back(mk(1,0,32'h0,  0,32'h0,       0, 0,0,32'h0,       0,32'h0,  0,1));
        vecs.push_back(mk(0,0,32'h0,  1,32'h45050505,0, 1,0,32'h0,       0,32'h0,  0,1));
        vecs.push_back(mk(0,0,32'h0,  0,32'h0,       1, 1,1,32'h00000505,1,32'h0,  2,1));
        vecs.push_back(mk(0,0,32'h0,  0,32'h0,       1, 1,1,32'h00004505,1,32'h2,  1,1));
        vecs.push_back(mk(0,0,32'h0,  0,32'h0,       0, 1,0,32'h0,       0,32'h4,  0,1));
        vecs.push_back(mk(1,0,32'h0,  0,32'h0,       0, 0,0,32'h0,       0,32'h0,  0,1));
        vecs.push_back(mk(0,0,32'h0,  1,32'h00934505,0, 1,0,32'h0,       0,32'h0,  0,1));
        vecs.push_back(mk(0,0,32'h0,  1,32'h00000013,1, 1,1,32'h00004505,1,32'h0,  2,1));
        vecs.push_back(mk(0,0,32'h0,  0,32'h0,       1, 1,1,32'h00130093,0,32'h2,  3,1));
        vecs.push_back(mk(0,0,32'h0,  0,32'h0,       0, 1,1,32'h0,       1,32'h6,  1,1));
        vecs.push_back(mk(0,1,32'h103,1,32'hDEADBEEF,1, 1,0,32'h0,       0,32'h6,  1,1));
        vecs.push_back(mk(0,0,32'h0,  1,32'hABCD1234,0, 1,0,32'h0,       0,32'h102,0,1));
        vecs.push_back(mk(0,0,32'h0,  0,32'h0,       0, 1,1,32'h0000ABCD,1,32'h102,1,1));
        vecs.push_back(mk(0,0,32'h0,  0,32'h0,       1, 1,1,32'h0000ABCD,1,32'h102,1,1));
        vecs.push_back(mk(0,0,32'h0,  0,32'h0,       0, 1,0,32'h0,       0,32'h104,0,1));

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i].rst, vecs[i].flush, vecs[i].fpc, vecs[i].fv, vecs[i].fdata, vecs[i].rdy);
            @(negedge clk);
            if (vecs[i].chk)
                check_outs($sformatf("vec%0d", i), vecs[i].ev, vecs[i].ei, vecs[i].ec,
                           vecs[i].epc, vecs[i].elv, vecs[i].efr);
            adv();
        end

        // Stall until full, then drain across the pointer wrap with a 32-bit head at slot 7.
        w[0] = 32'h1101_1001;
        w[1] = 32'h1301_1201;
        w[2] = 32'h1501_1401;
        w[3] = 32'hBEEF_1601;
        w[4] = 32'h5678_CAFE;
        apply(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        adv();
        for (int k = 0; k < 4; k++) begin
            apply(1'b0, 1'b0, 32'h0, 1'b1, w[k], 1'b0);
            @(negedge clk);
            check($sformatf("fill%0d.level", k), 32'(bus.o_level), 32'(2 * k));
            check($sformatf("fill%0d.fready", k), 32'(bus.o_fetch_ready), 32'h1);
            adv();
        end
        for (int k = 0; k < 2; k++) begin
            apply(1'b0, 1'b0, 32'h0, 1'b1, w[4], 1'b0);
            @(negedge clk);
            check($sformatf("full%0d.level", k), 32'(bus.o_level), 32'd8);
            check($sformatf("full%0d.fready", k), 32'(bus.o_fetch_ready), 32'h0);
            adv();
        end
        for (int k = 0; k < 7; k++) begin
            apply(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
            @(negedge clk);
            check_outs($sformatf("drain%0d", k), 1'b1, 32'h1001 + 32'(k) * 32'h100, 1'b1,
                       32'(2 * k), 8 - k, (8 - k) <= 6);
            adv();
        end
        apply(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        @(negedge clk);
        check_outs("partial0", 1'b0, 32'h0, 1'b0, 32'd14, 1, 1'b1);
        adv();
        apply(1'b0, 1'b0, 32'h0, 1'b1, w[4], 1'b1);
        @(negedge clk);
        check_outs("partial1", 1'b0, 32'h0, 1'b0, 32'd14, 1, 1'b1);
        adv();
        apply(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        @(negedge clk);
        check_outs("wrap32", 1'b1, 32'hCAFE_BEEF, 1'b0, 32'd14, 3, 1'b1);
        adv();
        apply(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        check_outs("afterwrap", 1'b1, 32'h0000_5678, 1'b1, 32'd18, 1, 1'b1);
        adv();

        // Randomized traffic against the halfword-queue model.
        mq.delete();
        mpc   = 32'h0;
        mskip = 1'b0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            r_rst   = (cyc == 0) || ($urandom_range(0, 199) == 0);
            r_flush = ($urandom_range(0, 39) == 0);
            r_fpc   = $urandom;
            r_fv    = ($urandom_range(0, 3) != 0);
            r_fdata = {rand_hw(), rand_hw()};
            r_rdy   = ($urandom_range(0, 2) != 0);
            apply(r_rst, r_flush, r_fpc, r_fv, r_fdata, r_rdy);

            n    = mq.size();
            e_fr = (n <= DEPTH_HW - 2);
            e_c  = (n > 0) && (mq[0][1:0] != 2'b11);
            e_v  = !r_flush && ((e_c && n >= 1) || (!e_c && n >= 2));
            e_i  = !e_v ? 32'h0 : (e_c ? {16'h0, mq[0]} : {mq[1], mq[0]});
            e_cc = e_v && e_c;

            @(negedge clk);
            if (cyc > 0)
                check_outs($sformatf("rnd%0d", cyc), e_v, e_i, e_cc, mpc, n, e_fr);
            adv();

            if (r_rst) begin
                mq.delete();
                mpc   = 32'h0;
                mskip = 1'b0;
            end else if (r_flush) begin
                mq.delete();
                mpc   = {r_fpc[31:1], 1'b0};
                mskip = r_fpc[1];
            end else begin
                if (e_v && r_rdy) begin
                    if (e_c) begin
                        void'(mq.pop_front());
                        mpc = mpc + 32'd2;
                    end else begin
                        void'(mq.pop_front());
                        void'(mq.pop_front());
                        mpc = mpc + 32'd4;
                    end
                end
                if (r_fv && e_fr) begin
                    if (mskip) begin
                        mq.push_back(r_fdata[31:16]);
                        mskip = 1'b0;
                    end else begin
                        mq.push_back(r_fdata[15:0]);
                        mq.push_back(r_fdata[31:16]);
                    end
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
